// File: rtl/ldpc_sparse_mult_arbiter.sv
// Round-robin scheduler sharing one LDPC sparse-multiply engine between N_REQ lanes.
// An in-flight tag FIFO records block ownership so engine output returns to its issuer.
module ldpc_sparse_mult_arbiter #(
   parameter int WIDTH        = 96,
   parameter int N_REQ        = 4,
   parameter int IN_BEATS     = 1,
   parameter int OUT_BEATS    = 11,
   parameter int MAX_INFLIGHT = 2
) (
   input  logic                             i_clock,
   input  logic                             i_reset,
   input  logic [N_REQ*WIDTH-1:0]           i_req_data,
   input  logic [N_REQ-1:0]                 i_req_valid,
   output logic [N_REQ-1:0]                 o_req_ready,
   output logic [WIDTH-1:0]                 o_eng_data,
   output logic                             o_eng_valid,
   input  logic                             i_eng_ready,
   input  logic [WIDTH-1:0]                 i_eng_data,
   input  logic                             i_eng_valid,
   output logic                             o_eng_ready,
   output logic [WIDTH-1:0]                 o_rsp_data,
   output logic [N_REQ-1:0]                 o_rsp_valid,
   input  logic [N_REQ-1:0]                 i_rsp_ready,
   output logic                             o_rsp_last,
   output logic [$clog2(MAX_INFLIGHT+1)-1:0] o_inflight,
   output logic                             o_err_orphan
);

   localparam int PW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int ICW = (IN_BEATS > 1) ? $clog2(IN_BEATS) : 1;
   localparam int OCW = (OUT_BEATS > 1) ? $clog2(OUT_BEATS) : 1;
   localparam int FPW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
   localparam int IFW = $clog2(MAX_INFLIGHT+1);

   typedef enum logic {ISS_ARB, ISS_LOCKED} iss_state_t;

   iss_state_t       state;
   logic [PW-1:0]    rr_ptr;
   logic [PW-1:0]    lock_lane;
   logic [ICW-1:0]   in_cnt;
   logic [OCW-1:0]   out_cnt;
   logic [PW-1:0]    tag_mem [MAX_INFLIGHT];
   logic [FPW-1:0]   wr_ptr;
   logic [FPW-1:0]   rd_ptr;
   logic [IFW-1:0]   count;
   logic             err_orphan;

   logic [PW-1:0]    cand;
   logic             cand_ok;
   logic [PW-1:0]    head;
   logic             fifo_empty;
   logic             rsp_hs;
   logic             pop;
   logic             push;
   logic             space;
   logic [PW-1:0]    iss_lane;
   logic             iss_valid;
   logic             iss_hs;

   function automatic logic [PW-1:0] lane_at(input logic [PW-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= N_REQ) s = s - N_REQ;
      return PW'(s);
   endfunction

   function automatic logic [PW-1:0] next_lane(input logic [PW-1:0] l);
      return (l == PW'(N_REQ-1)) ? '0 : l + 1'b1;
   endfunction

   function automatic logic [FPW-1:0] next_slot(input logic [FPW-1:0] p);
      return (p == FPW'(MAX_INFLIGHT-1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      cand    = '0;
      cand_ok = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (!cand_ok && i_req_valid[lane_at(rr_ptr, i)]) begin
            cand_ok = 1'b1;
            cand    = lane_at(rr_ptr, i);
         end
      end
   end

   assign fifo_empty = (count == '0);
   assign head       = tag_mem[rd_ptr];
   assign rsp_hs     = !i_reset && i_eng_valid && !fifo_empty && i_rsp_ready[head];
   assign pop        = rsp_hs && (out_cnt == OCW'(OUT_BEATS-1));
   // A pop in the same cycle frees the slot, so a full FIFO can still accept a push.
   assign space      = (count < IFW'(MAX_INFLIGHT)) || pop;

   always_comb begin
      if (state == ISS_ARB) begin
         iss_lane  = cand;
         iss_valid = cand_ok && space;
      end else begin
         iss_lane  = lock_lane;
         iss_valid = i_req_valid[lock_lane];
      end
   end

   always_comb begin
      o_req_ready = '0;
      if (!i_reset) begin
         if (state == ISS_ARB) begin
            if (cand_ok) o_req_ready[cand] = i_eng_ready && space;
         end else begin
            o_req_ready[lock_lane] = i_eng_ready;
         end
      end
   end

   assign o_eng_valid = !i_reset && iss_valid;
   assign o_eng_data  = i_req_data[iss_lane*WIDTH +: WIDTH];
   assign iss_hs      = o_eng_valid && i_eng_ready;
   assign push        = iss_hs && (state == ISS_ARB);

   always_comb begin
      o_rsp_valid = '0;
      if (!i_reset && i_eng_valid && !fifo_empty) o_rsp_valid[head] = 1'b1;
   end

   // With no owner the engine beat is swallowed so the engine cannot wedge.
   assign o_eng_ready  = i_reset ? 1'b0 : (fifo_empty ? i_eng_valid : i_rsp_ready[head]);
   assign o_rsp_data   = i_eng_data;
   assign o_rsp_last   = (out_cnt == OCW'(OUT_BEATS-1));
   assign o_inflight   = count;
   assign o_err_orphan = err_orphan;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state      <= ISS_ARB;
         rr_ptr     <= '0;
         lock_lane  <= '0;
         in_cnt     <= '0;
         out_cnt    <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         err_orphan <= 1'b0;
      end else begin
         case (state)
            ISS_ARB: begin
               if (iss_hs) begin
                  rr_ptr <= next_lane(cand);
                  if (IN_BEATS > 1) begin
                     state     <= ISS_LOCKED;
                     lock_lane <= cand;
                     in_cnt    <= ICW'(1);
                  end
               end
            end
            ISS_LOCKED: begin
               if (iss_hs) begin
                  if (in_cnt == ICW'(IN_BEATS-1)) begin
                     state  <= ISS_ARB;
                     in_cnt <= '0;
                  end else begin
                     in_cnt <= in_cnt + 1'b1;
                  end
               end
            end
            default: state <= ISS_ARB;
         endcase

         if (push) begin
            tag_mem[wr_ptr] <= cand;
            wr_ptr          <= next_slot(wr_ptr);
         end

         if (rsp_hs) out_cnt <= pop ? '0 : out_cnt + 1'b1;
         if (pop) rd_ptr <= next_slot(rd_ptr);

         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase

         if (i_eng_valid && fifo_empty) err_orphan <= 1'b1;
      end
   end

endmodule
